// File: rtl/instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : instruction_fetch
// Purpose : Fetch stage. Holds the PC, issues one-cycle read pulses to the
//           instruction memory, captures Ack'd words into the IF/ID register
//           (with a one-entry skid buffer), handles redirects and flags a
//           stuck memory through a WAIT timeout.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [31:0] MemAddress,
   output logic        MemReadEnable,
   input  logic        MemAck,
   input  logic [31:0] MemInstr,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        Stall,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        FetchError
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   // Timer value seen on the WAIT edge that completes TIMEOUT_CYCLES edges.
   localparam logic [7:0] c_timer_last = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_mem_addr;
   logic        r_mem_re;
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc4_d;
   logic        r_valid_d;
   logic        r_fetch_err;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;
   logic        r_discard;
   logic [7:0]  r_timer;

   logic        w_slot_free;
   logic [31:0] w_redir_pc;
   logic [31:0] w_mem_next;
   logic [31:0] w_skid_next;
   logic        w_timeout;
   logic        w_unused_bits;

   assign w_slot_free   = ~r_valid_d | ~Stall;
   assign w_redir_pc    = {RedirectPC[31:2], 2'b00};
   assign w_mem_next    = r_mem_addr + 32'd4;
   assign w_skid_next   = r_skid_pc + 32'd4;
   assign w_timeout     = (r_timer == c_timer_last);
   // Low redirect bits are forced to zero, so they are intentionally dropped.
   assign w_unused_bits = &{1'b0, RedirectPC[1:0]};

   // Fetch controller: PC, request pulse, IF/ID register, skid buffer, timeout.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_mem_addr   <= RESET_PC;
         r_mem_re     <= 1'b0;
         r_instr_d    <= 32'd0;
         r_pc_d       <= 32'd0;
         r_pc4_d      <= 32'd0;
         r_valid_d    <= 1'b0;
         r_fetch_err  <= 1'b0;
         r_skid_instr <= 32'd0;
         r_skid_pc    <= 32'd0;
         r_discard    <= 1'b0;
         r_timer      <= 8'd0;
      end else begin
         // The request is a single-cycle pulse unless REQ re-asserts it below.
         r_mem_re <= 1'b0;
         case (r_state)
            S_REQ: begin
               if (Redirect) begin
                  r_pc      <= w_redir_pc;
                  r_valid_d <= 1'b0;
               end else begin
                  if (!Stall) begin
                     r_valid_d <= 1'b0;
                  end
                  if (w_slot_free) begin
                     r_mem_addr <= r_pc;
                     r_mem_re   <= 1'b1;
                     r_timer    <= 8'd0;
                     r_state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (MemAck) begin
                  r_discard <= 1'b0;
                  if (Redirect || r_discard) begin
                     // Response belongs to a flushed path: drop it.
                     r_state <= S_REQ;
                     if (!Stall) begin
                        r_valid_d <= 1'b0;
                     end
                  end else if (w_slot_free) begin
                     r_instr_d <= MemInstr;
                     r_pc_d    <= r_mem_addr;
                     r_pc4_d   <= w_mem_next;
                     r_valid_d <= 1'b1;
                     r_pc      <= w_mem_next;
                     r_state   <= S_REQ;
                  end else begin
                     r_skid_instr <= MemInstr;
                     r_skid_pc    <= r_mem_addr;
                     r_pc         <= w_mem_next;
                     r_state      <= S_HOLD;
                  end
               end else if (w_timeout) begin
                  r_fetch_err <= 1'b1;
                  r_valid_d   <= 1'b0;
                  r_state     <= S_ERR;
               end else begin
                  r_timer <= r_timer + 8'd1;
                  if (!Stall) begin
                     r_valid_d <= 1'b0;
                  end
               end
               // Redirect wins over everything above except the timeout state.
               if (Redirect) begin
                  r_pc      <= w_redir_pc;
                  r_valid_d <= 1'b0;
                  if (!MemAck) begin
                     r_discard <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (Redirect) begin
                  r_pc      <= w_redir_pc;
                  r_valid_d <= 1'b0;
                  r_state   <= S_REQ;
               end else if (!Stall) begin
                  r_instr_d <= r_skid_instr;
                  r_pc_d    <= r_skid_pc;
                  r_pc4_d   <= w_skid_next;
                  r_valid_d <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_ERR: begin
               r_valid_d   <= 1'b0;
               r_fetch_err <= 1'b1;
            end
            default: begin
               r_state <= S_ERR;
            end
         endcase
      end
   end

   assign MemAddress    = r_mem_addr;
   assign MemReadEnable = r_mem_re;
   assign InstrD        = r_instr_d;
   assign PCD           = r_pc_d;
   assign PCPlus4D      = r_pc4_d;
   assign ValidD        = r_valid_d;
   assign FetchError    = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_instruction_fetch
// Purpose : Self-checking bench for instruction_fetch: directed scenarios
//           followed by randomized stall/redirect/ack-latency traffic checked
//           against a transaction-level model of the fetch stream.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        CLK;
   logic        RST_N;
   logic [31:0] MemAddress;
   logic        MemReadEnable;
   logic        MemAck;
   logic [31:0] MemInstr;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        Stall;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        FetchError;

   instruction_fetch #(
      .RESET_PC       (32'h0000_0100),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .MemAddress    (MemAddress),
      .MemReadEnable (MemReadEnable),
      .MemAck        (MemAck),
      .MemInstr      (MemInstr),
      .Redirect      (Redirect),
      .RedirectPC    (RedirectPC),
      .Stall         (Stall),
      .InstrD        (InstrD),
      .PCD           (PCD),
      .PCPlus4D      (PCPlus4D),
      .ValidD        (ValidD),
      .FetchError    (FetchError)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          checks;
   int          errors;
   int          consumed;
   logic [31:0] fetch_ptr;    // address the next request must carry
   logic [31:0] deliver_ptr;  // PC of the next instruction decode must receive
   logic [31:0] mem_addr;
   logic        mem_pend;
   logic        mem_noack;
   int          mem_wait;
   int          delay;

   // Instruction memory contents as a pure function of address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h0000_0100)      return 32'h8C01_0000;
      else if (a == 32'h0000_0104) return 32'h2002_0005;
      else                         return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs and memory, account for consumption/redirects,
   // take the edge, then check what the edge produced.
   task automatic step(input logic redir, input logic [31:0] rpc, input logic stall);
      logic        pv;
      logic [31:0] pi;
      logic [31:0] pp;
      Redirect   = redir;
      RedirectPC = rpc;
      Stall      = stall;
      MemAck     = 1'b0;
      if (mem_pend && !mem_noack) begin
         if (mem_wait == 0) begin
            MemAck   = 1'b1;
            mem_pend = 1'b0;
         end else begin
            mem_wait--;
         end
      end
      MemInstr = MemAck ? mem_fn(mem_addr) : $urandom;
      pv = ValidD;
      pi = InstrD;
      pp = PCD;
      if (pv && !stall && !redir) begin
         chk("deliver_pc", PCD, deliver_ptr);
         chk("deliver_instr", InstrD, mem_fn(deliver_ptr));
         chk("deliver_pc4", PCPlus4D, deliver_ptr + 32'd4);
         deliver_ptr = deliver_ptr + 32'd4;
         consumed++;
      end
      if (redir) begin
         fetch_ptr   = {rpc[31:2], 2'b00};
         deliver_ptr = fetch_ptr;
      end
      @(posedge CLK);
      #1;
      if (redir) begin
         chk("redirect_clears_valid", 32'(ValidD), 32'd0);
      end else if (pv && stall) begin
         chk("stall_hold_valid", 32'(ValidD), 32'd1);
         chk("stall_hold_instr", InstrD, pi);
         chk("stall_hold_pc", PCD, pp);
      end
      if (MemReadEnable) begin
         chk("pulse_addr", MemAddress, fetch_ptr);
         chk("one_outstanding", 32'(mem_pend), 32'd0);
         fetch_ptr = fetch_ptr + 32'd4;
         mem_pend  = 1'b1;
         mem_addr  = MemAddress;
         mem_wait  = delay;
      end
   endtask

   task automatic model_reset();
      mem_pend    = 1'b0;
      MemAck      = 1'b0;
      fetch_ptr   = 32'h100;
      deliver_ptr = 32'h100;
   endtask

   initial begin
      logic        seen;
      logic        rs;
      logic        rr;
      logic [31:0] rp;
      checks    = 0;
      errors    = 0;
      consumed  = 0;
      delay     = 1;
      mem_noack = 1'b0;
      mem_addr  = 32'd0;
      mem_wait  = 0;
      RST_N     = 1'b0;
      Redirect  = 1'b0;
      RedirectPC = 32'd0;
      Stall     = 1'b0;
      MemInstr  = 32'd0;
      model_reset();

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_addr", MemAddress, 32'h100);
      chk("rst_re", 32'(MemReadEnable), 32'd0);
      chk("rst_valid", 32'(ValidD), 32'd0);
      chk("rst_instr", InstrD, 32'd0);
      chk("rst_pcd", PCD, 32'd0);
      chk("rst_pc4", PCPlus4D, 32'd0);
      chk("rst_err", 32'(FetchError), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Basic fetch
      step(1'b0, 32'd0, 1'b0);
      chk("basic_re", 32'(MemReadEnable), 32'd1);
      chk("basic_addr", MemAddress, 32'h100);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_one_cycle", 32'(MemReadEnable), 32'd0);
      chk("basic_not_yet_valid", 32'(ValidD), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("basic_valid", 32'(ValidD), 32'd1);
      chk("basic_instr", InstrD, 32'h8C01_0000);
      chk("basic_pcd", PCD, 32'h100);
      chk("basic_pc4", PCPlus4D, 32'h104);

      // Stall holds the D outputs and blocks requests
      step(1'b0, 32'd0, 1'b1);
      chk("stall_no_pulse", 32'(MemReadEnable), 32'd0);
      step(1'b0, 32'd0, 1'b1);
      chk("stall_no_pulse2", 32'(MemReadEnable), 32'd0);
      chk("stall_instr", InstrD, 32'h8C01_0000);
      step(1'b0, 32'd0, 1'b0);
      chk("next_pulse_104", MemAddress, 32'h104);
      chk("next_pulse_re", 32'(MemReadEnable), 32'd1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      chk("stall_ack_valid", 32'(ValidD), 32'd1);
      chk("stall_ack_instr", InstrD, 32'h2002_0005);
      chk("stall_ack_pcd", PCD, 32'h104);
      step(1'b0, 32'd0, 1'b1);
      chk("stall_ack_no_pulse", 32'(MemReadEnable), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_108", MemAddress, 32'h108);

      // Redirect in WAIT one cycle before Ack
      step(1'b1, 32'h200, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("discard_valid", 32'(ValidD), 32'd0);
      chk("discard_no_pulse", 32'(MemReadEnable), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_200", MemAddress, 32'h200);
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("fetch_200_valid", 32'(ValidD), 32'd1);
      chk("fetch_200_pcd", PCD, 32'h200);

      // Redirect coincident with Ack
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      step(1'b1, 32'h300, 1'b0);
      chk("coinc_valid", 32'(ValidD), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_300", MemAddress, 32'h300);
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("fetch_300_pcd", PCD, 32'h300);
      step(1'b1, 32'h1000, 1'b1);
      chk("redir_over_stall", 32'(ValidD), 32'd0);

      // Wrap-around and alignment
      step(1'b1, 32'hFFFF_FFFC, 1'b0);
      chk("redir_no_issue", 32'(MemReadEnable), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_fffc", MemAddress, 32'hFFFF_FFFC);
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("wrap_pc4", PCPlus4D, 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_wrap_0", MemAddress, 32'd0);
      step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      step(1'b1, 32'h203, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("pulse_aligned_200", MemAddress, 32'h200);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         delay = int'($urandom_range(1, 3));
         rs = ($urandom_range(0, 9) < 3);
         rr = ($urandom_range(0, 19) == 0);
         rp = $urandom;
         step(rr, rp, rs);
      end
      chk("random_progress", 32'(consumed > 60), 32'd1);

      // Async reset in the middle of a request pulse
      delay = 1;
      seen  = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         step(1'b0, 32'd0, 1'b0);
         seen = MemReadEnable;
      end
      chk("pulse_before_reset", 32'(seen), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_re", 32'(MemReadEnable), 32'd0);
      chk("async_rst_addr", MemAddress, 32'h100);
      chk("async_rst_valid", 32'(ValidD), 32'd0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;

      // Timeout: memory never answers
      mem_noack = 1'b1;
      step(1'b0, 32'd0, 1'b0);
      chk("to_pulse", 32'(MemReadEnable), 32'd1);
      repeat (15) step(1'b0, 32'd0, 1'b0);
      chk("to_not_yet", 32'(FetchError), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      chk("to_error", 32'(FetchError), 32'd1);
      chk("to_valid", 32'(ValidD), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h400, 1'b0);
         chk("err_no_pulse", 32'(MemReadEnable), 32'd0);
      end
      chk("err_sticky", 32'(FetchError), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_err", 32'(FetchError), 32'd0);
      chk("async_rst_re2", 32'(MemReadEnable), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
